// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: tracks in-flight GPR writes from E onward, drives per-port
// forward selects and load-use stalls, and sequences exception redirects around cache stalls.
module hazard_scoreboard #(
  parameter int          NUM_RD    = 2,
  parameter int          NUM_STG   = 3,
  parameter int          LAT_W     = 2,
  parameter logic [31:0] EXC_VEC   = 32'hBFC00380,
  parameter logic [31:0] ERET_CODE = 32'h0000000e,
  parameter int          PERF_W    = 32,
  localparam int         SW        = $clog2(NUM_STG + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ext_stall,
  input  logic                 issue_valid_d,
  input  logic                 issue_wen_d,
  input  logic [4:0]           issue_wreg_d,
  input  logic [LAT_W-1:0]     issue_lat_d,
  input  logic [5*NUM_RD-1:0]  rd_addr_d,
  input  logic [NUM_RD-1:0]    rd_used_d,
  output logic [SW*NUM_RD-1:0] fwd_sel_d,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 bubble_e,
  output logic                 stall_pipe,
  input  logic [31:0]          except_type_m,
  input  logic [31:0]          epc_m,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 flush_all,
  output logic [PERF_W-1:0]    stall_cycles
);

  typedef enum logic [1:0] {IDLE, WAIT, FIRE} excState_t;

  logic [NUM_STG:1]   sbValid;
  logic [4:0]         sbReg [1:NUM_STG];
  logic [LAT_W-1:0]   sbLat [1:NUM_STG];
  logic [NUM_RD-1:0]  portHazard;
  logic               hazard;
  logic               issueOk;
  excState_t          excState, excStateNext;
  logic               captureExc;
  logic [31:0]        excTarget;

  // A result becomes forwardable from the stage at whose end it exists; before that it is a hazard.
  always_comb begin
    int hitStg;
    int hitLat;
    fwd_sel_d  = '0;
    portHazard = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      hitStg = 0;
      hitLat = 0;
      for (int s = NUM_STG; s >= 1; s--) begin
        if (rd_used_d[p] && rd_addr_d[p*5 +: 5] != 5'd0 && sbValid[s] &&
            sbReg[s] == rd_addr_d[p*5 +: 5]) begin
          hitStg = s;
          hitLat = int'(sbLat[s]);
        end
      end
      if (hitStg != 0) begin
        if (hitStg >= hitLat) fwd_sel_d[p*SW +: SW] = SW'(hitStg);
        else                  portHazard[p] = 1'b1;
      end
    end
  end

  assign hazard     = |portHazard;
  assign stall_pipe = ext_stall;
  assign stall_f    = ext_stall | (hazard & ~flush_all);
  assign stall_d    = ext_stall | (hazard & ~flush_all);
  assign bubble_e   = hazard & ~ext_stall & ~flush_all;
  assign issueOk    = issue_valid_d & issue_wen_d & (issue_wreg_d != 5'd0) & ~stall_d & ~flush_all;

  always_ff @(posedge clk) begin
    if (rst || flush_all) begin
      sbValid <= '0;
    end else if (!ext_stall) begin
      for (int s = NUM_STG; s >= 2; s--) begin
        sbValid[s] <= sbValid[s-1];
        sbReg[s]   <= sbReg[s-1];
        sbLat[s]   <= sbLat[s-1];
      end
      sbValid[1] <= issueOk;
      sbReg[1]   <= issue_wreg_d;
      sbLat[1]   <= issue_lat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (bubble_e && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

  assign excTarget = (except_type_m == ERET_CODE) ? epc_m : EXC_VEC;

  always_ff @(posedge clk) begin
    if (rst) begin
      excState    <= IDLE;
      redirect_pc <= '0;
    end else begin
      excState <= excStateNext;
      if (captureExc) redirect_pc <= excTarget;
    end
  end

  // Exceptions arriving while a redirect is already pending are dropped.
  always_comb begin
    excStateNext   = excState;
    captureExc     = 1'b0;
    redirect_valid = 1'b0;
    case (excState)
      IDLE: begin
        if (except_type_m != 32'd0) begin
          captureExc   = 1'b1;
          excStateNext = ext_stall ? WAIT : FIRE;
        end
      end
      WAIT: begin
        if (!ext_stall) excStateNext = FIRE;
      end
      FIRE: begin
        redirect_valid = 1'b1;
        excStateNext   = IDLE;
      end
      default: excStateNext = IDLE;
    endcase
  end

  assign flush_all = redirect_valid;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised bench for hazard_scoreboard: a queue-of-in-flight-writes reference model
// predicts each cycle's outputs; a separate monitor pops and compares them.
module tb_hazard_scoreboard;

  localparam int NUM_RD  = 2;
  localparam int NUM_STG = 3;
  localparam int SW      = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 ext_stall;
  logic                 issue_valid_d;
  logic                 issue_wen_d;
  logic [4:0]           issue_wreg_d;
  logic [1:0]           issue_lat_d;
  logic [5*NUM_RD-1:0]  rd_addr_d;
  logic [NUM_RD-1:0]    rd_used_d;
  logic [SW*NUM_RD-1:0] fwd_sel_d;
  logic                 stall_f, stall_d, bubble_e, stall_pipe;
  logic [31:0]          except_type_m, epc_m;
  logic                 redirect_valid;
  logic [31:0]          redirect_pc;
  logic                 flush_all;
  logic [31:0]          stall_cycles;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .ext_stall(ext_stall),
    .issue_valid_d(issue_valid_d), .issue_wen_d(issue_wen_d),
    .issue_wreg_d(issue_wreg_d), .issue_lat_d(issue_lat_d),
    .rd_addr_d(rd_addr_d), .rd_used_d(rd_used_d), .fwd_sel_d(fwd_sel_d),
    .stall_f(stall_f), .stall_d(stall_d), .bubble_e(bubble_e), .stall_pipe(stall_pipe),
    .except_type_m(except_type_m), .epc_m(epc_m),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_all(flush_all), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst, ext, iv, iw;
    int          wreg, lat, ra0, ra1;
    bit [1:0]    used;
    logic [31:0] exc, epc;
  } stim_t;

  typedef struct {
    logic [3:0]  fwd;
    logic        stallF, stallD, bubble, stallPipe, redir, flush;
    logic [31:0] pc, cycles;
    bit          checkPc;
  } expect_t;

  typedef struct { int rg; int lat; int stg; } flight_t;

  expect_t     expQ[$];
  flight_t     inflight[$];
  bit          pending, fireNow, targetZero;
  logic [31:0] mTarget, mCount;
  int          checks = 0;
  int          passed = 0;

  function automatic stim_t nop();
    stim_t s;
    s.rst = 0; s.ext = 0; s.iv = 0; s.iw = 0; s.wreg = 0; s.lat = 1;
    s.ra0 = 0; s.ra1 = 0; s.used = 2'b00; s.exc = 32'd0; s.epc = 32'd0;
    return s;
  endfunction

  // Drives one D-stage cycle, predicts its outputs, then advances the model past the next edge.
  task automatic applyStimulus(input stim_t s);
    expect_t e;
    bit      hazard, flush;
    int      best, addr;
    flight_t tmp;
    @(posedge clk); #1;
    rst = s.rst; ext_stall = s.ext; issue_valid_d = s.iv; issue_wen_d = s.iw;
    issue_wreg_d = 5'(s.wreg); issue_lat_d = 2'(s.lat);
    rd_addr_d = {5'(s.ra1), 5'(s.ra0)}; rd_used_d = s.used;
    except_type_m = s.exc; epc_m = s.epc;

    flush = fireNow;
    hazard = 0;
    e.fwd = 4'd0;
    for (int p = 0; p < NUM_RD; p++) begin
      addr = (p == 0) ? s.ra0 : s.ra1;
      best = -1;
      if (s.used[p] && addr != 0)
        for (int i = 0; i < inflight.size(); i++)
          if (inflight[i].rg == addr && (best < 0 || inflight[i].stg < inflight[best].stg))
            best = i;
      if (best >= 0) begin
        if (inflight[best].stg >= inflight[best].lat) e.fwd[p*SW +: SW] = 2'(inflight[best].stg);
        else hazard = 1;
      end
    end
    e.stallF    = s.ext | (hazard & ~flush);
    e.stallD    = e.stallF;
    e.bubble    = hazard & ~s.ext & ~flush;
    e.stallPipe = s.ext;
    e.redir     = flush;
    e.flush     = flush;
    e.pc        = mTarget;
    e.checkPc   = flush | targetZero;
    e.cycles    = mCount;
    expQ.push_back(e);

    if (s.rst) begin
      inflight.delete();
      pending = 0; fireNow = 0; mTarget = 32'd0; targetZero = 1; mCount = 32'd0;
    end else begin
      if (flush) begin
        inflight.delete();
      end else if (!s.ext) begin
        for (int i = inflight.size() - 1; i >= 0; i--) begin
          tmp = inflight[i];
          tmp.stg++;
          if (tmp.stg > NUM_STG) inflight.delete(i);
          else inflight[i] = tmp;
        end
        if (s.iv && s.iw && s.wreg != 0 && !hazard) begin
          tmp.rg = s.wreg; tmp.lat = s.lat; tmp.stg = 1;
          inflight.push_front(tmp);
        end
      end
      if (e.bubble && mCount != 32'hFFFF_FFFF) mCount++;
      if (fireNow) begin
        fireNow = 0;
      end else if (pending) begin
        if (!s.ext) begin pending = 0; fireNow = 1; end
      end else if (s.exc != 32'd0) begin
        mTarget = (s.exc == 32'h0000000e) ? s.epc : 32'hBFC00380;
        targetZero = 0;
        if (s.ext) pending = 1; else fireNow = 1;
      end
    end
  endtask

  task automatic compareField(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  task automatic checkOutput(input expect_t e);
    compareField("fwd_sel_d", 32'(fwd_sel_d), 32'(e.fwd));
    compareField("stall_f", 32'(stall_f), 32'(e.stallF));
    compareField("stall_d", 32'(stall_d), 32'(e.stallD));
    compareField("bubble_e", 32'(bubble_e), 32'(e.bubble));
    compareField("stall_pipe", 32'(stall_pipe), 32'(e.stallPipe));
    compareField("redirect_valid", 32'(redirect_valid), 32'(e.redir));
    compareField("flush_all", 32'(flush_all), 32'(e.flush));
    compareField("stall_cycles", stall_cycles, e.cycles);
    if (e.checkPc) compareField("redirect_pc", redirect_pc, e.pc);
  endtask

  // Monitor: every sampled cycle consumes one prediction from the queue.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    int    drain;
    rst = 1; ext_stall = 0; issue_valid_d = 0; issue_wen_d = 0; issue_wreg_d = 0;
    issue_lat_d = 0; rd_addr_d = 0; rd_used_d = 0; except_type_m = 0; epc_m = 0;
    pending = 0; fireNow = 0; mTarget = 0; targetZero = 1; mCount = 0;
    repeat (2) @(posedge clk);

    // ALU r3, then read it as it walks E, M, W and retires
    s = nop(); s.iv = 1; s.iw = 1; s.wreg = 3; s.lat = 1; applyStimulus(s);
    repeat (4) begin s = nop(); s.ra0 = 3; s.used = 2'b01; applyStimulus(s); end

    // Load r4 with an immediate use on port 1
    s = nop(); s.iv = 1; s.iw = 1; s.wreg = 4; s.lat = 2; applyStimulus(s);
    repeat (2) begin s = nop(); s.ra1 = 4; s.used = 2'b10; applyStimulus(s); end
    repeat (3) applyStimulus(nop());

    // Younger load shadows older ALU result; r0 writes are ignored
    s = nop(); s.iv = 1; s.iw = 1; s.wreg = 4; s.lat = 1; applyStimulus(s);
    s = nop(); s.iv = 1; s.iw = 1; s.wreg = 4; s.lat = 2; applyStimulus(s);
    repeat (2) begin s = nop(); s.ra0 = 4; s.used = 2'b01; applyStimulus(s); end
    s = nop(); s.iv = 1; s.iw = 1; s.wreg = 0; s.lat = 2; applyStimulus(s);
    s = nop(); s.ra0 = 0; s.ra1 = 0; s.used = 2'b11; applyStimulus(s);
    repeat (3) applyStimulus(nop());

    // Load-use under three external stall cycles
    s = nop(); s.iv = 1; s.iw = 1; s.wreg = 4; s.lat = 2; applyStimulus(s);
    repeat (3) begin s = nop(); s.ra0 = 4; s.used = 2'b01; s.ext = 1; applyStimulus(s); end
    repeat (2) begin s = nop(); s.ra0 = 4; s.used = 2'b01; applyStimulus(s); end
    repeat (3) applyStimulus(nop());

    // Exception held in WAIT by a stall, then released; scoreboard is flushed
    s = nop(); s.iv = 1; s.iw = 1; s.wreg = 5; s.lat = 1; applyStimulus(s);
    repeat (2) begin s = nop(); s.exc = 32'd1; s.ext = 1; applyStimulus(s); end
    s = nop(); s.ra0 = 5; s.used = 2'b01; applyStimulus(s);
    repeat (2) begin s = nop(); s.ra0 = 5; s.used = 2'b01; applyStimulus(s); end

    // ERET to EPC; the issue in the flush cycle is dropped
    s = nop(); s.exc = 32'h0000000e; s.epc = 32'hBFC00100; applyStimulus(s);
    s = nop(); s.iv = 1; s.iw = 1; s.wreg = 6; s.lat = 1; applyStimulus(s);
    repeat (2) begin s = nop(); s.ra0 = 6; s.used = 2'b01; applyStimulus(s); end

    // Reset while waiting drops the redirect
    s = nop(); s.exc = 32'd3; s.ext = 1; applyStimulus(s);
    s = nop(); s.ext = 1; s.rst = 1; applyStimulus(s);
    repeat (3) applyStimulus(nop());

    // Randomised traffic over a small register set to provoke overlaps
    repeat (1500) begin
      s = nop();
      s.rst  = ($urandom_range(0, 199) == 0);
      s.ext  = ($urandom_range(0, 99) < 15);
      s.iv   = ($urandom_range(0, 9) < 8);
      s.iw   = ($urandom_range(0, 9) < 7);
      s.wreg = $urandom_range(0, 5);
      s.lat  = $urandom_range(0, 3);
      s.ra0  = $urandom_range(0, 5);
      s.ra1  = $urandom_range(0, 5);
      s.used = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 4)
        s.exc = ($urandom_range(0, 1) == 1) ? 32'h0000000e : 32'($urandom_range(1, 20));
      s.epc  = $urandom;
      applyStimulus(s);
    end

    drain = 0;
    while (expQ.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    #1;
    if (expQ.size() > 0) begin
      checks++;
      $display("[TB] FAIL drain: %0d predictions left, expected 0", expQ.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
